// File: rtl/p2s_pkg.sv
// p2s_conv_4x1 shared types: nibble/counter widths and shifter state.
// Optional input buffer is selected with P2S_IN_BUF_EN.
package p2s_pkg;

    localparam int NIB_W = 4;
    localparam int CNT_W = 2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NIB_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } p2s_state_t;

endpackage

// File: rtl/p2s_if.sv
// Nibble stream bundle: data + sop with valid/req handshake.
// A nibble transfers on val & req.
interface p2s_if
    import p2s_pkg::*;
();

    logic [NIB_W-1:0] dat;
    logic             sop;
    logic             val;
    logic             req;

    modport master (output dat, output sop, output val, input req);
    modport slave  (input dat, input sop, input val, output req);

endinterface

// File: rtl/p2s_in_buf.sv
// One-entry nibble buffer; req is a registered "empty" so the
// upstream side has no combinational path from downstream req.
module p2s_in_buf
    import p2s_pkg::*;
(
    input logic clk,
    input logic rst_n,
    p2s_if.slave  up,
    p2s_if.master dn
);

    logic [NIB_W-1:0] data;
    logic             sop;
    logic             full;
    logic             rdy;
    logic             push;
    logic             pop;
    logic             full_nxt;

    assign push     = up.val & rdy;
    assign pop      = full & dn.req;
    assign full_nxt = push | (full & ~pop);

    assign up.req = rdy;
    assign dn.val = full;
    assign dn.dat = data;
    assign dn.sop = sop;

    // rdy stays low through reset and rises on the first clock after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            sop  <= 1'b0;
            full <= 1'b0;
            rdy  <= 1'b0;
        end else begin
            full <= full_nxt;
            rdy  <= ~full_nxt;
            if (push) begin
                data <= up.dat;
                sop  <= up.sop;
            end
        end
    end

endmodule

// File: rtl/p2s_conv_4x1.sv
// 4-bit parallel to serial converter, LSB first, SOP on first bit.
// Define P2S_IN_BUF_EN to put a one-entry buffer ahead of the shifter.
module p2s_conv_4x1
    import p2s_pkg::*;
(
    input  logic             iclk,
    input  logic             irst,
    input  logic [NIB_W-1:0] idat,
    input  logic             isop,
    input  logic             ival,
    output logic             oreq,
    input  logic             ireq,
    output logic             oval,
    output logic             osop,
    output logic             odat
);

    logic [NIB_W-1:0] nib_dat;
    logic             nib_sop;
    logic             nib_val;
    logic             nib_req;

`ifdef P2S_IN_BUF_EN
    p2s_if up_if ();
    p2s_if sh_if ();

    assign up_if.dat = idat;
    assign up_if.sop = isop;
    assign up_if.val = ival;
    assign oreq      = up_if.req;

    assign nib_dat   = sh_if.dat;
    assign nib_sop   = sh_if.sop;
    assign nib_val   = sh_if.val;
    assign sh_if.req = nib_req;

    p2s_in_buf u_buf (
        .clk   (iclk),
        .rst_n (irst),
        .up    (up_if.slave),
        .dn    (sh_if.master)
    );
`else
    assign nib_dat = idat;
    assign nib_sop = isop;
    assign nib_val = ival;
    assign oreq    = nib_req;
`endif

    p2s_state_t       state;
    logic [NIB_W-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic             sop_q;
    logic             last;
    logic             load;

    assign last    = (bit_cnt == LAST_BIT);
    assign nib_req = (state == IDLE) |
                     ((state == SHIFT) & last & ireq);
    assign load    = nib_val & nib_req;

    assign odat = shreg[0];
    assign oval = (state == SHIFT);
    assign osop = oval & sop_q & (bit_cnt == '0);

    // a new nibble may replace the last bit in the same cycle
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            sop_q   <= 1'b0;
        end else if (load) begin
            state   <= SHIFT;
            shreg   <= nib_dat;
            bit_cnt <= '0;
            sop_q   <= nib_sop;
        end else if ((state == SHIFT) && ireq) begin
            if (last) begin
                state <= IDLE;
            end else begin
                shreg   <= {1'b0, shreg[NIB_W-1:1]};
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_p2s_conv_4x1.sv
// Directed bench for p2s_conv_4x1; adapts latency and reset oreq
// expectations when P2S_IN_BUF_EN is defined.
module tb_p2s_conv_4x1;
    import p2s_pkg::*;

`ifdef P2S_IN_BUF_EN
    localparam int   LAT     = 2;
    localparam logic RST_REQ = 1'b0;
    localparam bit   UPCHK   = 1'b0;
`else
    localparam int   LAT     = 1;
    localparam logic RST_REQ = 1'b1;
    localparam bit   UPCHK   = 1'b1;
`endif

    logic iclk = 1'b0;
    logic irst;
    logic ireq;
    logic oval;
    logic osop;
    logic odat;

    p2s_if up ();

    p2s_conv_4x1 dut (
        .iclk (iclk),
        .irst (irst),
        .idat (up.dat),
        .isop (up.sop),
        .ival (up.val),
        .oreq (up.req),
        .ireq (ireq),
        .oval (oval),
        .osop (osop),
        .odat (odat)
    );

    always #5 iclk = ~iclk;

    int checks   = 0;
    int failures = 0;

    logic [3:0] tx_dat[$];
    bit         tx_sop[$];
    bit         exp_bit[$];
    bit         exp_sop[$];
    bit         rx_bit[$];
    bit         rx_sop[$];
    int         acc_cyc;
    int         first_cyc;
    int         last_cyc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_nib(input logic [3:0] d, input bit s);
        tx_dat.push_back(d);
        tx_sop.push_back(s);
        for (int j = 0; j < 4; j++) begin
            exp_bit.push_back(d[j]);
            exp_sop.push_back(s && j == 0);
        end
    endtask

    // drive/monitor loop; called at posedge+1
    task automatic run(input int abort_after, input int stall_after,
                       input int stall_len, input bit rand_req,
                       input bit upchk);
        int cyc = 0;
        int stalled = 0;
        bit stall_now;
        rx_bit.delete();
        rx_sop.delete();
        acc_cyc   = -1;
        first_cyc = -1;
        last_cyc  = -1;
        while (rx_bit.size() < exp_bit.size() && cyc < 400) begin
            if (abort_after >= 0 && rx_bit.size() == abort_after) break;
            if (tx_dat.size() > 0) begin
                up.val = 1'b1;
                up.dat = tx_dat[0];
                up.sop = tx_sop[0];
            end else begin
                up.val = 1'b0;
                up.dat = 4'($urandom);
                up.sop = 1'b1;
            end
            stall_now = stall_len > 0 && rx_bit.size() == stall_after &&
                        stalled < stall_len;
            if (rand_req) ireq = ($urandom_range(3) != 0);
            else          ireq = !stall_now;
            @(negedge iclk);
            if (stall_now) begin
                stalled++;
                chk("stall_oval", 32'(oval), 32'd1);
                chk("stall_odat", 32'(odat), 32'(exp_bit[rx_bit.size()]));
            end
            if (upchk && up.val && oval && (rx_bit.size() % 4) != 3)
                chk("upstall_oreq", 32'(up.req), 32'd0);
            if (up.val && up.req) begin
                if (acc_cyc < 0) acc_cyc = cyc;
                void'(tx_dat.pop_front());
                void'(tx_sop.pop_front());
            end
            if (oval && ireq) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                rx_bit.push_back(odat);
                rx_sop.push_back(osop);
            end
            @(posedge iclk);
            #1;
            cyc++;
        end
        up.val = 1'b0;
        ireq   = 1'b1;
        if (cyc >= 400) chk("timeout", 32'(cyc), 32'd0);
    endtask

    task automatic verify(input string tag);
        chk({tag, "_nbits"}, 32'(rx_bit.size()), 32'(exp_bit.size()));
        for (int i = 0; i < rx_bit.size() && i < exp_bit.size(); i++) begin
            chk($sformatf("%s_bit%0d", tag, i),
                32'(rx_bit[i]), 32'(exp_bit[i]));
            chk($sformatf("%s_sop%0d", tag, i),
                32'(rx_sop[i]), 32'(exp_sop[i]));
        end
        exp_bit.delete();
        exp_sop.delete();
    endtask

    initial begin
        irst   = 1'b0;
        ireq   = 1'b1;
        up.val = 1'b0;
        up.dat = 4'h0;
        up.sop = 1'b0;
        repeat (2) @(posedge iclk);
        @(negedge iclk);
        chk("rst_oval", 32'(oval), 32'd0);
        chk("rst_osop", 32'(osop), 32'd0);
        chk("rst_odat", 32'(odat), 32'd0);
        chk("rst_oreq", 32'(up.req), 32'(RST_REQ));
        @(posedge iclk);
        #1 irst = 1'b1;
        @(posedge iclk);
        #1;

        // single SOP nibble 1011 -> 1,1,0,1
        push_nib(4'b1011, 1'b1);
        run(-1, 0, 0, 1'b0, UPCHK);
        chk("single_latency", 32'(first_cyc - acc_cyc), 32'(LAT));
        verify("single");
        @(negedge iclk);
        chk("single_idle_oval", 32'(oval), 32'd0);
        @(posedge iclk);
        #1;

        // back-to-back 5, A with ival held; also upstream stall
        push_nib(4'h5, 1'b0);
        push_nib(4'hA, 1'b0);
        run(-1, 0, 0, 1'b0, UPCHK);
        chk("b2b_span", 32'(last_cyc - first_cyc + 1), 32'd8);
        verify("b2b");

        // backpressure: 3 stall cycles pending bit 2 of 6
        push_nib(4'h6, 1'b1);
        run(-1, 2, 3, 1'b0, UPCHK);
        verify("bp");

        // reset after 2 bits of F
        push_nib(4'hF, 1'b0);
        run(2, 0, 0, 1'b0, UPCHK);
        irst = 1'b0;
        #2;
        chk("mid_rst_oval", 32'(oval), 32'd0);
        chk("mid_rst_osop", 32'(osop), 32'd0);
        chk("mid_rst_odat", 32'(odat), 32'd0);
        chk("mid_rst_oreq", 32'(up.req), 32'(RST_REQ));
        exp_bit.delete();
        exp_sop.delete();
        tx_dat.delete();
        tx_sop.delete();
        @(posedge iclk);
        #1 irst = 1'b1;
        @(posedge iclk);
        #1;
        @(negedge iclk);
        chk("post_rst_oval", 32'(oval), 32'd0);
        @(posedge iclk);
        #1;
        push_nib(4'h3, 1'b0);
        run(-1, 0, 0, 1'b0, UPCHK);
        verify("after_rst");

        // loopback: random nibbles, SOP every 16th, random ireq
        for (int i = 0; i < 32; i++)
            push_nib(4'($urandom), i % 16 == 0);
        run(-1, 0, 0, 1'b1, UPCHK);
        verify("loop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
